mult_bcd_conv: RTL
==================

MULT_BCD_CONV -- requirements
Module: mult_bcd_conv

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bit width of the incoming unsigned product.
REQ-002 SHALL have parameter DIGITS, default 5, number of BCD output digits; DIGITS*3.33 >= WIDTH.
REQ-003 SHALL have port Clk_System  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port lowRst_System  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port prod_valid  input  1  product from the upstream multiplier is valid this cycle.
REQ-006 SHALL have port prod_data  input  WIDTH  unsigned product from the upstream multiplier.
REQ-007 SHALL have port prod_ready  output  1  block is able to accept a product (IDLE).
REQ-008 SHALL have port bcd_out  output  DIGITS*4  converted result, least-significant digit in bits [3:0].
REQ-009 SHALL have port bcd_valid  output  1  one-cycle pulse marking a new bcd_out.
REQ-010 SHALL have port busy  output  1  conversion in progress.
REQ-011 SHALL have port seg_out  output  DIGITS*7  active-low gfedcba segments per digit; present only with MULT_BCD_SEG7_EN.

Function
REQ-012 SHALL implement FSM states IDLE, CONVERT, DONE.
REQ-013 SHALL, in IDLE with prod_valid=1, capture prod_data into a shift register, clear the BCD accumulator, load iteration counter with WIDTH, and enter CONVERT.
REQ-014 SHALL, each CONVERT cycle, add 3 to every BCD digit >= 5, then shift {BCD,shift register} left by one, and decrement the counter.
REQ-015 SHALL leave CONVERT for DONE in the cycle the counter reaches 0, i.e. after exactly WIDTH shifts.
REQ-016 SHALL, in DONE, register the accumulator into bcd_out, pulse bcd_valid for exactly one cycle, and return to IDLE.
REQ-017 SHALL assert bcd_valid WIDTH+1 cycles after the accepting edge (17 cycles for WIDTH=16).
REQ-018 SHALL drive prod_ready=1 only in IDLE; busy=1 in CONVERT and DONE.
REQ-019 SHALL ignore prod_valid while not in IDLE; the dropped product leaves no effect.
REQ-020 SHALL accept a new product in the IDLE cycle that immediately follows DONE (back-to-back throughput WIDTH+2 cycles).
REQ-021 SHALL hold bcd_out stable from one bcd_valid until the next bcd_valid.
REQ-022 SHALL convert prod_data=0 to all-zero digits and 2^WIDTH-1 without overflow.

Reset
REQ-023 SHALL, on lowRst_System=0, immediately force IDLE, bcd_out=0, bcd_valid=0, busy=0, prod_ready=0 until release, shift register and counter=0.
REQ-024 SHALL abort a conversion in progress on reset without emitting bcd_valid; prod_ready=1 on the first edge after release.

Configuration
REQ-025 SHALL, with macro MULT_BCD_SEG7_EN defined, provide seg_out as a combinational decode of bcd_out (0->1000000, 8->0000000, codes 10-15 -> 1111111).
REQ-026 SHALL, without MULT_BCD_SEG7_EN, omit seg_out and all decode logic; all other behaviour is identical.

Structure
REQ-027 SHALL take WIDTH/DIGITS defaults, the FSM state encoding and the 7-segment code constants from shared package mult_pkg.
REQ-028 SHALL place the per-digit 7-segment decode in sub-module seg7_dec, instantiated DIGITS times under MULT_BCD_SEG7_EN.

Verification
REQ-029 SHALL test prod_data=0x3039 pulsed in IDLE -> bcd_valid 17 cycles later, bcd_out=0x12345.
REQ-030 SHALL test prod_data=0xFFFF -> bcd_out=0x65535; prod_data=0x0000 -> bcd_out=0x00000.
REQ-031 SHALL test 0x2649 (99*99) accepted, then 0x0001 pulsed during CONVERT -> single bcd_valid, bcd_out=0x09801, second product ignored.
REQ-032 SHALL test lowRst_System=0 at cycle 8 of a conversion -> no bcd_valid, bcd_out=0, busy=0; after release, 0x00FF -> bcd_out=0x00255.
REQ-033 SHALL test back-to-back: 0x0064 then 0x03E8 presented at first prod_ready -> bcd_out 0x00100 then 0x01000, pulses 18 cycles apart.
REQ-034 SHALL test, with MULT_BCD_SEG7_EN, bcd_out=0x00008 -> seg_out digit0=0000000, digits1-4=1000000.

Source files
------------

// File: rtl/mult_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mult_pkg : shared defaults, FSM encoding and 7-segment codes            |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
package mult_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int DIGITS_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Active-low segments, bit order gfedcba.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Double-dabble correction applied to each digit before every shift.
  function automatic logic [3:0] add3_ge5(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_dec.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | seg7_dec : one BCD digit to active-low gfedcba segments (10-15 blank)   |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
module seg7_dec
  import mult_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mult_bcd_conv.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mult_bcd_conv : binary product to BCD (double dabble); MULT_BCD_SEG7_EN |
// | adds a 7-segment decode of bcd_out.            Revision : 1.0           |
// +-------------------------------------------------------------------------+
module mult_bcd_conv
  import mult_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  Clk_System,
  input  logic                  lowRst_System,
  input  logic                  prod_valid,
  input  logic [WIDTH-1:0]      prod_data,
  output logic                  prod_ready,
  output logic [DIGITS*4-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic                  busy
`ifdef MULT_BCD_SEG7_EN
  ,
  output logic [DIGITS*7-1:0]   seg_out
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      sr_q, sr_d;
  logic [DIGITS*4-1:0]   bcd_q, bcd_d;
  logic [DIGITS*4-1:0]   bcd_out_q, bcd_out_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  bcd_valid_q, bcd_valid_d;
  logic                  ready_q, ready_d;
  logic [DIGITS*4-1:0]   adj;

  always_ff @(posedge Clk_System or negedge lowRst_System) begin
    if (!lowRst_System) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      bcd_q       <= '0;
      bcd_out_q   <= '0;
      cnt_q       <= '0;
      bcd_valid_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bcd_q       <= bcd_d;
      bcd_out_q   <= bcd_out_d;
      cnt_q       <= cnt_d;
      bcd_valid_q <= bcd_valid_d;
      ready_q     <= ready_d;
    end
  end

  always_comb begin
    adj         = '0;
    state_d     = state_q;
    sr_d        = sr_q;
    bcd_d       = bcd_q;
    bcd_out_d   = bcd_out_q;
    cnt_d       = cnt_q;
    bcd_valid_d = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[i*4 +: 4] = add3_ge5(bcd_q[i*4 +: 4]);
    end
    case (state_q)
      ST_IDLE: begin
        // ready_q gates acceptance so nothing is taken on the first edge after reset.
        if (prod_valid && ready_q) begin
          sr_d    = prod_data;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        {bcd_d, sr_d} = {adj, sr_q} << 1;
        cnt_d         = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_out_d   = bcd_q;
        bcd_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  assign prod_ready = ready_q;
  assign bcd_out    = bcd_out_q;
  assign bcd_valid  = bcd_valid_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef MULT_BCD_SEG7_EN
  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    seg7_dec u_dec (
      .digit_i (bcd_out_q[g*4 +: 4]),
      .seg_o   (seg_out[g*7 +: 7])
    );
  end
`endif

endmodule
`default_nettype wire
